// File: rtl/sram_port_arb_if.sv
// Signal bundle between the SRAM port arbiter, its requesters and the dual-port SRAM.
// slave = arbiter side, master = requesters plus SRAM side.
interface sram_port_arb_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 16
);
    logic [NUM_REQ-1:0]         wr_req;
    logic [NUM_REQ*ADDR_W-1:0]  wr_addr;
    logic [NUM_REQ*DATA_W-1:0]  wr_data;
    logic [NUM_REQ-1:0]         wr_gnt;

    logic [NUM_REQ-1:0]         rd_req;
    logic [NUM_REQ*ADDR_W-1:0]  rd_addr;
    logic [NUM_REQ-1:0]         rd_gnt;
    logic                       rd_vld;
    logic [$clog2(NUM_REQ)-1:0] rd_id;
    logic [DATA_W-1:0]          rd_data;

    logic                       sram_en_a;
    logic [ADDR_W-1:0]          sram_addr_a;
    logic [DATA_W-1:0]          sram_data_a;
    logic                       sram_en_b;
    logic [ADDR_W-1:0]          sram_addr_b;
    logic [DATA_W-1:0]          sram_dout;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_dout,
        output wr_gnt, rd_gnt, rd_vld, rd_id, rd_data,
        output sram_en_a, sram_addr_a, sram_data_a, sram_en_b, sram_addr_b
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_dout,
        input  wr_gnt, rd_gnt, rd_vld, rd_id, rd_data,
        input  sram_en_a, sram_addr_a, sram_data_a, sram_en_b, sram_addr_b
    );
endinterface

// File: rtl/sram_port_arb.sv
// Independent round-robin write/read arbiters in front of a dual-port SRAM, 1-cycle read return.
// Define SRAM_ARB_COLLISION_FWD_EN to forward write data to a same-cycle, same-address read.
module sram_port_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 16
) (
    input logic            sys_clk,
    input logic            sys_rst_n,
    sram_port_arb_if.slave bus
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef logic [IdW-1:0] idx_t;
    typedef struct packed {
        logic hit;
        idx_t idx;
    } pick_t;

    // First requesting index at or after ptr, wrapping past NUM_REQ-1.
    function automatic pick_t rr_pick(logic [NUM_REQ-1:0] req, idx_t ptr);
        pick_t       p;
        int unsigned k;
        p = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = 32'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!p.hit && req[idx_t'(k)]) begin
                p.hit = 1'b1;
                p.idx = idx_t'(k);
            end
        end
        return p;
    endfunction

    function automatic idx_t ptr_after(idx_t idx);
        return (idx == idx_t'(NUM_REQ - 1)) ? '0 : idx + idx_t'(1);
    endfunction

    idx_t  wr_ptr_q, wr_ptr_d;
    idx_t  rd_ptr_q, rd_ptr_d;
    pick_t wr_pick, rd_pick;
    logic  rd_vld_q;
    idx_t  rd_id_q;

    always_comb begin
        wr_pick = rr_pick(bus.wr_req, wr_ptr_q);
        rd_pick = rr_pick(bus.rd_req, rd_ptr_q);
        if (!sys_rst_n) begin
            wr_pick.hit = 1'b0;
            rd_pick.hit = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_pick.hit) wr_ptr_d = ptr_after(wr_pick.idx);
        if (rd_pick.hit) rd_ptr_d = ptr_after(rd_pick.idx);
    end

    always_comb begin
        bus.wr_gnt      = '0;
        bus.rd_gnt      = '0;
        bus.sram_en_a   = wr_pick.hit;
        bus.sram_addr_a = '0;
        bus.sram_data_a = '0;
        bus.sram_en_b   = rd_pick.hit;
        bus.sram_addr_b = '0;
        if (wr_pick.hit) begin
            bus.wr_gnt[wr_pick.idx] = 1'b1;
            bus.sram_addr_a = bus.wr_addr[32'(wr_pick.idx) * ADDR_W +: ADDR_W];
            bus.sram_data_a = bus.wr_data[32'(wr_pick.idx) * DATA_W +: DATA_W];
        end
        if (rd_pick.hit) begin
            bus.rd_gnt[rd_pick.idx] = 1'b1;
            bus.sram_addr_b = bus.rd_addr[32'(rd_pick.idx) * ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rd_vld_q <= 1'b0;
            rd_id_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rd_vld_q <= rd_pick.hit;
            rd_id_q  <= rd_pick.idx;
        end
    end

    // Gating with the reset input keeps an in-flight read from surfacing once reset asserts.
    assign bus.rd_vld = rd_vld_q & sys_rst_n;
    assign bus.rd_id  = sys_rst_n ? rd_id_q : '0;

`ifdef SRAM_ARB_COLLISION_FWD_EN
    logic              wr_vld_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] rd_addr_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            wr_vld_q  <= wr_pick.hit;
            wr_addr_q <= bus.sram_addr_a;
            wr_data_q <= bus.sram_data_a;
            rd_addr_q <= bus.sram_addr_b;
        end
    end

    // SRAM returns pre-write contents on a same-cycle collision; substitute the new data.
    assign bus.rd_data = (rd_vld_q && wr_vld_q && (wr_addr_q == rd_addr_q)) ? wr_data_q
                                                                             : bus.sram_dout;
`else
    assign bus.rd_data = bus.sram_dout;
`endif

endmodule

// File: tb/tb_sram_port_arb.sv
// Randomized and directed bench for sram_port_arb against a queue/array reference model.
module tb_sram_port_arb;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 16;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    always #5 sys_clk = ~sys_clk;

    sram_port_arb_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_port_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    // Read-first dual-port SRAM: read data appears one cycle after sram_en_b.
    logic [DW-1:0] sram_mem [1 << AW];
    logic [DW-1:0] sram_q;
    always @(posedge sys_clk) begin
        if (bus.sram_en_a) sram_mem[bus.sram_addr_a] <= bus.sram_data_a;
        if (bus.sram_en_b) sram_q <= sram_mem[bus.sram_addr_b];
    end
    assign bus.sram_dout = sram_q;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [N-1:0] req, input int unsigned ptr);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (int'(ptr) + i) % N;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    // Reference model state
    int unsigned   m_wptr = 0, m_rptr = 0, m_id = 0;
    bit            m_vld = 1'b0, m_known = 1'b0;
    logic [DW-1:0] m_data;
    logic [DW-1:0] ref_mem [1 << AW];
    bit            ref_known [1 << AW];

    initial begin
        int            w, r;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        logic [N-1:0]  eg, erg;
        forever begin
            @(negedge sys_clk);
            w  = sys_rst_n ? rr(bus.wr_req, m_wptr) : -1;
            r  = sys_rst_n ? rr(bus.rd_req, m_rptr) : -1;
            wa = '0; wd = '0; ra = '0; eg = '0; erg = '0;
            if (w >= 0) begin
                eg[w] = 1'b1;
                wa = bus.wr_addr[w*AW +: AW];
                wd = bus.wr_data[w*DW +: DW];
            end
            if (r >= 0) begin
                erg[r] = 1'b1;
                ra = bus.rd_addr[r*AW +: AW];
            end
            chk("wr_gnt", 32'(bus.wr_gnt), 32'(eg));
            chk("rd_gnt", 32'(bus.rd_gnt), 32'(erg));
            chk("sram_en_a", 32'(bus.sram_en_a), 32'(w >= 0));
            chk("sram_addr_a", 32'(bus.sram_addr_a), 32'(wa));
            chk("sram_data_a", 32'(bus.sram_data_a), 32'(wd));
            chk("sram_en_b", 32'(bus.sram_en_b), 32'(r >= 0));
            chk("sram_addr_b", 32'(bus.sram_addr_b), 32'(ra));
            chk("rd_vld", 32'(bus.rd_vld), 32'(m_vld && sys_rst_n));
            if (!sys_rst_n) chk("rd_id_rst", 32'(bus.rd_id), 32'(0));
            if (sys_rst_n && m_vld) begin
                chk("rd_id", 32'(bus.rd_id), 32'(m_id));
                if (m_known) chk("rd_data", 32'(bus.rd_data), 32'(m_data));
            end
            if (!sys_rst_n) begin
                m_wptr = 0;
                m_rptr = 0;
                m_vld  = 1'b0;
            end else begin
                m_vld = (r >= 0);
                if (r >= 0) begin
                    m_id    = r;
                    m_rptr  = (r + 1) % N;
                    m_known = ref_known[ra];
                    m_data  = ref_mem[ra];
`ifdef SRAM_ARB_COLLISION_FWD_EN
                    if (w >= 0 && wa == ra) begin
                        m_known = 1'b1;
                        m_data  = wd;
                    end
`endif
                end
                if (w >= 0) begin
                    m_wptr        = (w + 1) % N;
                    ref_mem[wa]   = wd;
                    ref_known[wa] = 1'b1;
                end
            end
        end
    end

    logic [AW-1:0] w_addr [N];
    logic [DW-1:0] w_data [N];
    logic [AW-1:0] r_addr [N];

    task automatic drive(input logic [N-1:0] wm, input logic [N-1:0] rm);
        bus.wr_req = wm;
        bus.rd_req = rm;
        for (int i = 0; i < N; i++) begin
            bus.wr_addr[i*AW +: AW] = w_addr[i];
            bus.wr_data[i*DW +: DW] = w_data[i];
            bus.rd_addr[i*AW +: AW] = r_addr[i];
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] wq, rq, g_w, g_r;
        logic [DW-1:0] collide_exp;
        sys_rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_addr[i] = AW'(14'h100 + i);
            w_data[i] = DW'(16'hA000 + i);
            r_addr[i] = AW'(14'h100 + i);
        end
        drive(4'b1111, 4'b1111);
        // Requests present during reset must not be granted
        repeat (3) begin
            @(negedge sys_clk);
            chk("rst_wr_gnt", 32'(bus.wr_gnt), 32'h0);
            chk("rst_rd_gnt", 32'(bus.rd_gnt), 32'h0);
            chk("rst_en_a", 32'(bus.sram_en_a), 32'h0);
            chk("rst_rd_vld", 32'(bus.rd_vld), 32'h0);
            chk("rst_rd_id", 32'(bus.rd_id), 32'h0);
            cyc();
        end
        sys_rst_n = 1'b1;
        drive(4'b1111, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            @(negedge sys_clk);
            chk("wr_rr_seq", 32'(bus.wr_gnt), 32'(1 << k));
        end

        // Requester 2 writes 0xBEEF to 0x0010, requester 0 reads it back
        cyc();
        w_addr[2] = 14'h0010;
        w_data[2] = 16'hBEEF;
        drive(4'b0100, 4'b0000);
        @(negedge sys_clk);
        chk("beef_wr_gnt", 32'(bus.wr_gnt), 32'b0100);
        chk("beef_data_a", 32'(bus.sram_data_a), 32'hBEEF);
        cyc();
        r_addr[0] = 14'h0010;
        drive(4'b0000, 4'b0001);
        @(negedge sys_clk);
        chk("beef_rd_gnt", 32'(bus.rd_gnt), 32'b0001);
        chk("beef_vld_early", 32'(bus.rd_vld), 32'h0);
        cyc();
        drive(4'b0000, 4'b0000);
        @(negedge sys_clk);
        chk("beef_rd_vld", 32'(bus.rd_vld), 32'h1);
        chk("beef_rd_id", 32'(bus.rd_id), 32'h0);
        chk("beef_rd_data", 32'(bus.rd_data), 32'hBEEF);

        // Requester 3 read wraps the read pointer to 0, then 0101 alternates
        cyc();
        drive(4'b0000, 4'b1000);
        @(negedge sys_clk);
        chk("rd3_gnt", 32'(bus.rd_gnt), 32'b1000);
        r_addr[2] = 14'h0102;
        for (int k = 0; k < 4; k++) begin
            cyc();
            drive(4'b0000, 4'b0101);
            @(negedge sys_clk);
            chk("alt_rd_gnt", 32'(bus.rd_gnt), (k % 2 == 0) ? 32'b0001 : 32'b0100);
            chk("alt_rd_vld", 32'(bus.rd_vld), 32'h1);
            chk("alt_rd_id", 32'(bus.rd_id), (k == 0) ? 32'd3 : ((k % 2 == 1) ? 32'd0 : 32'd2));
        end
        cyc();
        drive(4'b0000, 4'b0000);
        @(negedge sys_clk);
        chk("alt_last_vld", 32'(bus.rd_vld), 32'h1);
        chk("alt_last_id", 32'(bus.rd_id), 32'd2);
        chk("alt_last_data", 32'(bus.rd_data), 32'hA002);

        // Same-cycle write and read of 0x3FFF
        cyc();
        w_addr[1] = 14'h3FFF;
        w_data[1] = 16'h1111;
        drive(4'b0010, 4'b0000);
        @(negedge sys_clk);
        chk("col_wr1_gnt", 32'(bus.wr_gnt), 32'b0010);
        cyc();
        w_data[1] = 16'h2222;
        r_addr[1] = 14'h3FFF;
        drive(4'b0010, 4'b0010);
        @(negedge sys_clk);
        chk("col_wr2_gnt", 32'(bus.wr_gnt), 32'b0010);
        chk("col_rd_gnt", 32'(bus.rd_gnt), 32'b0010);
        cyc();
        drive(4'b0000, 4'b0000);
        @(negedge sys_clk);
`ifdef SRAM_ARB_COLLISION_FWD_EN
        collide_exp = 16'h2222;
`else
        collide_exp = 16'h1111;
`endif
        chk("col_rd_vld", 32'(bus.rd_vld), 32'h1);
        chk("col_rd_data", 32'(bus.rd_data), 32'(collide_exp));

        // Read granted, then reset: no rd_vld pulse, pointers back to 0
        cyc();
        drive(4'b0000, 4'b0001);
        @(negedge sys_clk);
        chk("prst_rd_gnt", 32'(bus.rd_gnt), 32'b0001);
        cyc();
        sys_rst_n = 1'b0;
        drive(4'b0000, 4'b0000);
        @(negedge sys_clk);
        chk("prst_rd_vld", 32'(bus.rd_vld), 32'h0);
        cyc();
        sys_rst_n = 1'b1;
        drive(4'b1111, 4'b1111);
        @(negedge sys_clk);
        chk("post_rst_rd_vld", 32'(bus.rd_vld), 32'h0);
        chk("post_rst_rd_gnt", 32'(bus.rd_gnt), 32'b0001);
        chk("post_rst_wr_gnt", 32'(bus.wr_gnt), 32'b0001);

        // Idle for 10 cycles: nothing granted, pointers hold at 1
        for (int k = 0; k < 10; k++) begin
            cyc();
            drive(4'b0000, 4'b0000);
            @(negedge sys_clk);
            chk("idle_wr_gnt", 32'(bus.wr_gnt), 32'h0);
            chk("idle_rd_gnt", 32'(bus.rd_gnt), 32'h0);
            chk("idle_en_a", 32'(bus.sram_en_a), 32'h0);
            chk("idle_en_b", 32'(bus.sram_en_b), 32'h0);
        end
        cyc();
        drive(4'b1111, 4'b1111);
        @(negedge sys_clk);
        chk("idle_wptr", 32'(bus.wr_gnt), 32'b0010);
        chk("idle_rptr", 32'(bus.rd_gnt), 32'b0010);

        // Random traffic; requesters hold until their handshake
        wq = '0; rq = '0; g_w = '0; g_r = '0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            for (int i = 0; i < N; i++) begin
                if (wq[i] && g_w[i]) wq[i] = 1'b0;
                if (rq[i] && g_r[i]) rq[i] = 1'b0;
                if (!wq[i] && $urandom_range(0, 2) == 0) begin
                    wq[i] = 1'b1;
                    w_addr[i] = AW'($urandom_range(0, 31));
                    w_data[i] = DW'($urandom);
                end
                if (!rq[i] && $urandom_range(0, 2) == 0) begin
                    rq[i] = 1'b1;
                    r_addr[i] = AW'($urandom_range(0, 31));
                end
            end
            sys_rst_n = ($urandom_range(0, 249) != 0);
            drive(wq, rq);
            @(negedge sys_clk);
            g_w = bus.wr_gnt;
            g_r = bus.rd_gnt;
        end
        cyc();
        sys_rst_n = 1'b1;
        drive(4'b0000, 4'b0000);
        repeat (3) @(negedge sys_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/sram_port_arb.md
SRAM_PORT_ARB -- requirements
Module: sram_port_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 14, giving the SRAM word-address width.
REQ-003 SHALL have parameter DATA_W, default 16, giving the SRAM data width.
REQ-004 SHALL have port sys_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port sys_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port wr_req, input, NUM_REQ bits: per-requester write request.
REQ-007 SHALL have port wr_addr, input, NUM_REQ*ADDR_W bits: packed write addresses, requester i at slice i.
REQ-008 SHALL have port wr_data, input, NUM_REQ*DATA_W bits: packed write data.
REQ-009 SHALL have port wr_gnt, output, NUM_REQ bits: one-hot write grant.
REQ-010 SHALL have port rd_req, input, NUM_REQ bits: per-requester read request.
REQ-011 SHALL have port rd_addr, input, NUM_REQ*ADDR_W bits: packed read addresses.
REQ-012 SHALL have port rd_gnt, output, NUM_REQ bits: one-hot read grant.
REQ-013 SHALL have port rd_vld, output, 1 bit: read data valid.
REQ-014 SHALL have port rd_id, output, $clog2(NUM_REQ) bits: requester index owning rd_data.
REQ-015 SHALL have port rd_data, output, DATA_W bits: returned read data.
REQ-016 SHALL have ports sram_en_a, sram_addr_a, sram_data_a (outputs, 1/ADDR_W/DATA_W bits) driving the SRAM write port.
REQ-017 SHALL have ports sram_en_b, sram_addr_b (outputs, 1/ADDR_W bits) driving the SRAM read port, and sram_dout (input, DATA_W bits) carrying SRAM read data, valid one cycle after sram_en_b.

Function
REQ-018 SHALL arbitrate write and read requests independently, each with its own round-robin pointer; at most one write and one read are granted per cycle.
REQ-019 SHALL compute grants combinationally from the current requests and pointer; a requester holds its request, address and data until it sees its grant bit high at a clock edge (handshake = req & gnt).
REQ-020 SHALL give priority, in each arbiter, to the first requesting index at or after the pointer, wrapping from NUM_REQ-1 to 0.
REQ-021 SHALL, on a granted transfer, advance that arbiter's pointer to granted index + 1 modulo NUM_REQ; with no grant the pointer holds.
REQ-022 SHALL drive the SRAM write port combinationally from the winner: sram_en_a = |wr_gnt, with address and data of the winning slice; address and data are 0 when idle.
REQ-023 SHALL drive sram_en_b = |rd_gnt and sram_addr_b combinationally from the read winner in the same way.
REQ-024 SHALL register the read winner's index and a valid flag, then assert rd_vld and rd_id exactly one cycle after the grant, with rd_data = sram_dout (total latency 1 cycle).
REQ-025 SHALL sustain back-to-back reads with one result per cycle.
REQ-026 SHALL register the granted write address and data alongside the read pipeline, for use by REQ-032.
REQ-027 SHALL drive all grants to 0 when no request is present.

Reset
REQ-028 SHALL, while sys_rst_n = 0 at a clock edge, set both pointers to 0 and clear the read pipeline valid, index, captured write address and captured write data.
REQ-029 SHALL hold rd_vld = 0 and rd_id = 0 while in reset, and force wr_gnt, rd_gnt, sram_en_a and sram_en_b to 0 while sys_rst_n = 0.
REQ-030 SHALL discard a read granted in the cycle before reset asserts; rd_vld SHALL NOT pulse after reset.

Configuration
REQ-031 SHALL compile a same-address read/write collision bypass only when macro SRAM_ARB_COLLISION_FWD_EN is defined.
REQ-032 SHALL, with the macro defined, return the written data (not stale SRAM contents) on rd_data when a read and a write to the same address are granted in the same cycle.
REQ-033 SHALL, without the macro, pass sram_dout unchanged, returning the old SRAM contents on a same-cycle collision.

Verification
REQ-034 Bench SHALL cover: wr_req=4'b1111 held for 4 cycles from reset -> wr_gnt sequence 0001, 0010, 0100, 1000.
REQ-035 Bench SHALL cover: requester 2 writes 0xBEEF to addr 0x0010, then requester 0 reads 0x0010 -> rd_vld one cycle after rd_gnt[0], with rd_id=0 and rd_data=0xBEEF.
REQ-036 Bench SHALL cover: rd_req=4'b0101 held for 4 cycles -> rd_gnt 0001, 0100, 0001, 0100, with rd_vld high on 4 consecutive cycles and ids 0, 2, 0, 2.
REQ-037 Bench SHALL cover: addr 0x3FFF holding 0x1111, then same-cycle write 0x2222 and read of 0x3FFF -> rd_data 0x2222 with the macro defined, 0x1111 without it.
REQ-038 Bench SHALL cover: a read granted, then sys_rst_n=0 at the next edge -> rd_vld stays 0 and the next grant after reset goes to index 0.
REQ-039 Bench SHALL cover: no requests -> all grants 0, sram_en_a=sram_en_b=0, and pointers unchanged over 10 cycles.
